// File: rtl/psum_accumulator.sv
// Output-stationary accumulator for the systolic array's bottom-row partial sums.
// Sums a programmable number of passes per lane and hands the vector to writeback.
module psum_accumulator #(
    parameter int WIDTH  = 16,
    parameter int COLS   = 4,
    parameter int PASS_W = 5
) (
    input  logic                    clk,
    input  logic                    arst_n_in,
    input  logic                    start,
    input  logic [PASS_W-1:0]       num_passes,
    input  logic [COLS*WIDTH-1:0]   psum_in,
    input  logic                    psum_valid,
    output logic [COLS*WIDTH-1:0]   acc_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    drop_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    logic [PASS_W-1:0] cnt_q;
    logic [PASS_W-1:0] tgt_q;
    logic [WIDTH-1:0]  lane_q [COLS];
    logic              out_valid_q;
    logic              busy_q;
    logic              drop_err_q;
    logic              last_pass;

    // Target is never 0, so cnt_q+1 cannot wrap before matching it.
    assign last_pass = ((cnt_q + PASS_W'(1)) == tgt_q);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tgt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_err_q  <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                lane_q[c] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        tgt_q      <= (num_passes == '0) ? PASS_W'(1) : num_passes;
                        cnt_q      <= '0;
                        drop_err_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                        for (int c = 0; c < COLS; c++) begin
                            lane_q[c] <= '0;
                        end
                    end else if (psum_valid) begin
                        drop_err_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (psum_valid) begin
                        for (int c = 0; c < COLS; c++) begin
                            lane_q[c] <= lane_q[c] + psum_in[c*WIDTH +: WIDTH];
                        end
                        cnt_q <= cnt_q + PASS_W'(1);
                        if (last_pass) begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (psum_valid) begin
                        drop_err_q <= 1'b1;
                    end
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < COLS; g++) begin : g_pack
        assign acc_out[g*WIDTH +: WIDTH] = lane_q[g];
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator against a per-lane sum model.
// Directed cases cover wrap, collisions, backpressure and reset mid-job.
module tb_psum_accumulator;

    logic        clk;
    logic        arst_n_in;
    logic        start;
    logic [4:0]  num_passes;
    logic [63:0] psum_in;
    logic        psum_valid;
    logic [63:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        drop_err;

    int n_chk;
    int n_pass;

    int          exp_l [4];
    bit          exp_drop;
    logic [63:0] vq [$];

    psum_accumulator #(.WIDTH(16), .COLS(4), .PASS_W(5)) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .start      (start),
        .num_passes (num_passes),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] p;
        p = '0;
        for (int c = 0; c < 4; c++) p[c*16 +: 16] = exp_l[c][15:0];
        return p;
    endfunction

    function automatic void model_add(input logic [63:0] v);
        for (int c = 0; c < 4; c++) begin
            exp_l[c] = (exp_l[c] + int'(v[c*16 +: 16])) % 65536;
        end
    endfunction

    function automatic logic [63:0] rand_vec();
        return {$urandom(), $urandom()};
    endfunction

    // bub < 0 selects a random 0..2 cycle gap before each pass
    task automatic job(input int np, input bit collide, input int bub,
                       input int hold, input bit hold_drop, input bit acc_start);
        int          tgt;
        int          nb;
        logic [63:0] v;
        tgt        = (np == 0) ? 1 : np;
        start      = 1'b1;
        num_passes = 5'(np);
        psum_valid = collide;
        psum_in    = rand_vec();
        step();
        start      = 1'b0;
        psum_valid = 1'b0;
        for (int c = 0; c < 4; c++) exp_l[c] = 0;
        exp_drop = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ov", 64'(out_valid), 64'd0);
        chk("start_acc", acc_out, 64'd0);
        chk("start_drop", 64'(drop_err), 64'd0);
        for (int i = 0; i < tgt; i++) begin
            nb = (bub < 0) ? int'($urandom_range(0, 2)) : bub;
            repeat (nb) begin
                start      = acc_start;
                num_passes = 5'd1;
                step();
                start = 1'b0;
            end
            v = (vq.size() > 0) ? vq.pop_front() : rand_vec();
            psum_in    = v;
            psum_valid = 1'b1;
            step();
            psum_valid = 1'b0;
            model_add(v);
            if (i < tgt - 1) begin
                chk("accum_ov", 64'(out_valid), 64'd0);
                chk("accum_acc", acc_out, model_vec());
            end
        end
        chk("done_ov", 64'(out_valid), 64'd1);
        chk("done_acc", acc_out, model_vec());
        repeat (hold) begin
            psum_valid = hold_drop & 1'($urandom_range(0, 1));
            psum_in    = 64'h0009_0009_0009_0009;
            if (psum_valid) exp_drop = 1'b1;
            step();
            psum_valid = 1'b0;
            chk("hold_ov", 64'(out_valid), 64'd1);
            chk("hold_acc", acc_out, model_vec());
            chk("hold_drop", 64'(drop_err), 64'(exp_drop));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_ov", 64'(out_valid), 64'd0);
        chk("hs_busy", 64'(busy), 64'd0);
        chk("hs_acc", acc_out, model_vec());
        chk("hs_drop", 64'(drop_err), 64'(exp_drop));
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        arst_n_in  = 1'b0;
        start      = 1'b0;
        num_passes = '0;
        psum_in    = '0;
        psum_valid = 1'b0;
        out_ready  = 1'b0;
        #3;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_acc", acc_out, 64'd0);
        chk("rst_drop", 64'(drop_err), 64'd0);
        #19 arst_n_in = 1'b1;
        step();

        vq.push_back({16'd4, 16'd3, 16'd2, 16'd1});
        job(1, 1'b0, 0, 0, 1'b0, 1'b0);

        vq.push_back({16'd40, 16'd30, 16'd20, 16'd10});
        vq.push_back({16'd1, 16'd1, 16'd1, 16'd1});
        vq.push_back({16'd0, 16'd5, 16'd0, 16'd5});
        job(3, 1'b0, 1, 0, 1'b0, 1'b0);
        chk("three_pass", acc_out, {16'd41, 16'd36, 16'd21, 16'd16});

        vq.push_back({48'd0, 16'hFFF0});
        vq.push_back({48'd0, 16'h0020});
        job(2, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("wrap_lane0", 64'(acc_out[15:0]), 64'h0010);

        job(0, 1'b0, 0, 0, 1'b0, 1'b0);

        vq.push_back({16'd8, 16'd7, 16'd6, 16'd5});
        job(1, 1'b0, 0, 5, 1'b1, 1'b0);
        job(2, 1'b1, 1, 1, 1'b0, 1'b1);

        psum_valid = 1'b1;
        psum_in    = rand_vec();
        step();
        psum_valid = 1'b0;
        chk("idle_drop", 64'(drop_err), 64'd1);
        chk("idle_acc_kept", acc_out, model_vec());
        job(1, 1'b0, 0, 0, 1'b0, 1'b0);

        start      = 1'b1;
        num_passes = 5'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psum_in    = rand_vec() | 64'h0001_0001_0001_0001;
            psum_valid = 1'b1;
            step();
        end
        psum_valid = 1'b0;
        #1 arst_n_in = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_acc", acc_out, 64'd0);
        #3 arst_n_in = 1'b1;
        step();
        job(1, 1'b0, 0, 0, 1'b0, 1'b0);

        for (int j = 0; j < 25; j++) begin
            job(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1,
                int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
